// File: rtl/aes_block_stream.sv
// rtl/aes_block_stream.sv - 32-bit word stream to 128-bit AES core adapter
//
// Purpose:
//   Packs four 32-bit plaintext words into a 128-bit block, queues blocks in
//   a DEPTH-entry FIFO, launches each block to the AES core, waits for the
//   ciphertext and unpacks it into four 32-bit output words. Supervises the
//   core with a timeout and an error flag, and counts completed blocks.
//
// Parameters:
//   DEPTH   - FIFO depth in 128-bit blocks (power of two, >= 1)
//   TIMEOUT - maximum cycles spent waiting for the core before abort
//
// Ports:
//   clk, resetn                    clock, asynchronous active-low reset
//   in_valid/in_ready/in_data      plaintext word stream (MSW of block first)
//   out_valid/out_ready/out_data   ciphertext word stream (MSW first)
//   out_last                       marks the fourth word of a block
//   aes_pt_valid, aes_pt           one-cycle launch pulse and block to core
//   aes_ct_rdy, aes_ct             core ciphertext ready level and data
//   aes_key_ready, aes_error       core key-expansion done, core error
//   clr_err                        clears both sticky error flags
//   busy                           FSM active or FIFO non-empty
//   err_timeout, err_aes           sticky supervision flags
//   blocks_done                    count of fully drained blocks (wraps)

module aes_block_stream #(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         aes_pt_valid,
  output logic [127:0] aes_pt,
  input  logic         aes_ct_rdy,
  input  logic [127:0] aes_ct,
  input  logic         aes_key_ready,
  input  logic         aes_error,
  input  logic         clr_err,
  output logic         busy,
  output logic         err_timeout,
  output logic         err_aes,
  output logic [15:0]  blocks_done
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     wcnt_q, wcnt_d;
  logic [95:0]    pack_q, pack_d;
  logic [127:0]   mem [DEPTH];
  logic [PW-1:0]  wptr_q, wptr_d;
  logic [PW-1:0]  rptr_q, rptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           in_ready_q;
  logic           key_q;
  logic [127:0]   pt_q, pt_d;
  logic           armed_q, armed_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [127:0]   ct_q, ct_d;
  logic [1:0]     idx_q, idx_d;
  logic [15:0]    done_q, done_d;
  logic           err_to_q, err_to_d;
  logic           err_aes_q, err_aes_d;
  logic           set_to, set_aes;
  logic           accept, push, pop;

  // ---------------------------------------------------------------------
  // Packer
  // ---------------------------------------------------------------------
  assign accept = in_valid && in_ready_q;
  assign push   = accept && (wcnt_q == 2'd3);

  always_comb begin
    wcnt_d = wcnt_q;
    pack_d = pack_q;
    if (accept) begin
      wcnt_d = wcnt_q + 2'd1;
      case (wcnt_q)
        2'd0:    pack_d[95:64] = in_data;
        2'd1:    pack_d[63:32] = in_data;
        2'd2:    pack_d[31:0]  = in_data;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Block FIFO
  // ---------------------------------------------------------------------
  // Launch requires the key-ready level on two consecutive cycles, so the
  // first launch after key expansion lands two cycles after it completes.
  assign pop = (state_q == S_IDLE) && (count_q != '0) && key_q && aes_key_ready;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= {pack_q, in_data};
    end
  end

  // ---------------------------------------------------------------------
  // Launch / wait / drain FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pt_d    = pt_q;
    armed_d = armed_q;
    timer_d = timer_q;
    ct_d    = ct_q;
    idx_d   = idx_q;
    done_d  = done_q;
    set_to  = 1'b0;
    set_aes = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          pt_d    = mem[rptr_q];
          armed_d = 1'b0;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A ready level still high from the previous block must be seen low
        // once before it can be trusted for this block.
        if (!aes_ct_rdy) begin
          armed_d = 1'b1;
        end
        if (aes_error) begin
          set_aes = 1'b1;
          state_d = S_IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          set_to  = 1'b1;
          state_d = S_IDLE;
        end else if (armed_q && aes_ct_rdy) begin
          ct_d    = aes_ct;
          idx_d   = 2'd0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            done_d  = done_q + 16'd1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // clr_err wins over a set in the same cycle.
  always_comb begin
    err_to_d  = clr_err ? 1'b0 : (err_to_q  | set_to);
    err_aes_d = clr_err ? 1'b0 : (err_aes_q | set_aes);
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      pack_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      key_q      <= 1'b0;
      pt_q       <= '0;
      armed_q    <= 1'b0;
      timer_q    <= '0;
      ct_q       <= '0;
      idx_q      <= '0;
      done_q     <= '0;
      err_to_q   <= 1'b0;
      err_aes_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      pack_q     <= pack_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      // Registered from the next count: a pop never opens space for a push
      // in the same cycle.
      in_ready_q <= (count_d != CW'(DEPTH));
      key_q      <= aes_key_ready;
      pt_q       <= pt_d;
      armed_q    <= armed_d;
      timer_q    <= timer_d;
      ct_q       <= ct_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
      err_to_q   <= err_to_d;
      err_aes_q  <= err_aes_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    out_data = '0;
    case (idx_q)
      2'd0:    out_data = ct_q[127:96];
      2'd1:    out_data = ct_q[95:64];
      2'd2:    out_data = ct_q[63:32];
      default: out_data = ct_q[31:0];
    endcase
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (state_q == S_DRAIN);
  assign out_last     = (state_q == S_DRAIN) && (idx_q == 2'd3);
  assign aes_pt_valid = (state_q == S_LAUNCH);
  assign aes_pt       = pt_q;
  assign busy         = (state_q != S_IDLE) || (count_q != '0);
  assign err_timeout  = err_to_q;
  assign err_aes      = err_aes_q;
  assign blocks_done  = done_q;

endmodule

// File: tb/tb_aes_block_stream.sv
// tb/tb_aes_block_stream.sv - directed self-checking bench for aes_block_stream

module tb_aes_block_stream;

  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic         aes_pt_valid;
  logic [127:0] aes_pt;
  logic         aes_ct_rdy;
  logic [127:0] aes_ct;
  logic         aes_key_ready;
  logic         aes_error;
  logic         clr_err;
  logic         busy;
  logic         err_timeout;
  logic         err_aes;
  logic [15:0]  blocks_done;

  int errors = 0;
  int checks = 0;

  logic [31:0]  got_w [16];
  logic         got_l [16];
  int           got_n;
  logic [127:0] c_pt;
  int           c_del;

  aes_block_stream #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .aes_pt_valid  (aes_pt_valid),
    .aes_pt        (aes_pt),
    .aes_ct_rdy    (aes_ct_rdy),
    .aes_ct        (aes_ct),
    .aes_key_ready (aes_key_ready),
    .aes_error     (aes_error),
    .clr_err       (clr_err),
    .busy          (busy),
    .err_timeout   (err_timeout),
    .err_aes       (err_aes),
    .blocks_done   (blocks_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    resetn     = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    aes_ct_rdy = 1'b0;
    aes_ct     = '0;
    aes_error  = 1'b0;
    clr_err    = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  // Sends the four words of blk, MSW first; returns in the slot after the
  // fourth word was accepted.
  task automatic send_block(input logic [127:0] blk);
    for (int i = 0; i < 4; i++) begin
      int w;
      in_valid = 1'b1;
      in_data  = blk[127 - 32*i -: 32];
      w = 0;
      while (!in_ready && w < 200) begin
        tick();
        w++;
      end
      if (w >= 200) begin
        checks++;
        errors++;
        $display("FAIL send_wait: in_ready=%0b required 1 within 200 cycles", in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Acts as the core (ciphertext = ~plaintext, ready two cycles after the
  // launch slot) and collects n output words with out_ready held high.
  task automatic serve_collect(input int n);
    int cyc;
    got_n     = 0;
    c_del     = 0;
    cyc       = 0;
    out_ready = 1'b1;
    while (got_n < n && cyc < 400) begin
      if (aes_pt_valid) begin
        c_pt       = aes_pt;
        c_del      = 2;
        aes_ct_rdy = 1'b0;
      end else if (c_del > 0) begin
        c_del--;
        if (c_del == 0) begin
          aes_ct     = ~c_pt;
          aes_ct_rdy = 1'b1;
        end
      end
      if (out_valid) begin
        got_w[got_n] = out_data;
        got_l[got_n] = out_last;
        got_n++;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (got_n !== n) begin
      errors++;
      $display("FAIL collect_count: got %0d words required %0d", got_n, n);
    end
  endtask

  task automatic test_reset();
    resetn        = 1'b0;
    in_valid      = 1'b0;
    in_data       = '0;
    out_ready     = 1'b0;
    aes_ct_rdy    = 1'b0;
    aes_ct        = '0;
    aes_key_ready = 1'b1;
    aes_error     = 1'b0;
    clr_err       = 1'b0;
    tick();
    tick();
    checks++;
    if ({in_ready, out_valid, out_last, aes_pt_valid, busy, err_timeout, err_aes} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: in_ready,out_valid,out_last,pt_valid,busy,err_to,err_aes=%b required 0000000",
               {in_ready, out_valid, out_last, aes_pt_valid, busy, err_timeout, err_aes});
    end
    checks++;
    if (aes_pt !== 128'h0 || blocks_done !== 16'h0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: aes_pt=%h blocks_done=%h out_data=%h required zeros", aes_pt, blocks_done, out_data);
    end
    resetn = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_single_fips();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h69c4e0d8;
    exp_w[1] = 32'h6a7b0430;
    exp_w[2] = 32'hd8cdb780;
    exp_w[3] = 32'h70b4c55a;
    send_block(128'h00112233445566778899aabbccddeeff);
    checks++;
    if (aes_pt_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse_n1: aes_pt_valid=%b required 0 at N+1", aes_pt_valid);
    end
    tick();
    checks++;
    if (aes_pt_valid !== 1'b1 || aes_pt !== 128'h00112233445566778899aabbccddeeff) begin
      errors++;
      $display("FAIL single_launch: aes_pt_valid=%b aes_pt=%h required 1 00112233445566778899aabbccddeeff",
               aes_pt_valid, aes_pt);
    end
    tick();
    checks++;
    if (aes_pt_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse_width: aes_pt_valid=%b required 0 at N+3", aes_pt_valid);
    end
    tick();
    aes_ct     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    aes_ct_rdy = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early_out: out_valid=%b required 0 in ct_rdy cycle", out_valid);
    end
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_w[i] || out_last !== (i == 3)) begin
        errors++;
        $display("FAIL single_word%0d: valid=%b data=%h last=%b required 1 %h %b",
                 i, out_valid, out_data, out_last, exp_w[i], (i == 3));
      end
      tick();
    end
    out_ready  = 1'b0;
    aes_ct_rdy = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || blocks_done !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: out_valid=%b blocks_done=%0d busy=%b required 0 1 0", out_valid, blocks_done, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] blk [3];
    logic         stall_ok;
    blk[0] = 128'h0123456789abcdef_fedcba9876543210;
    blk[1] = 128'h1111111122222222_3333333344444444;
    blk[2] = 128'ha5a5a5a55a5a5a5a_c3c3c3c33c3c3c3c;
    apply_reset();
    send_block(blk[0]);
    tick();
    tick();
    tick();
    aes_ct     = ~blk[0];
    aes_ct_rdy = 1'b1;
    tick();
    aes_ct_rdy = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== ~blk[0][127:96]) begin
      errors++;
      $display("FAIL bp_drain_start: out_valid=%b out_data=%h required 1 %h", out_valid, out_data, ~blk[0][127:96]);
    end
    send_block(blk[1]);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_one_queued: in_ready=%b required 1", in_ready);
    end
    send_block(blk[2]);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_fifo_full: in_ready=%b busy=%b required 0 1", in_ready, busy);
    end
    stall_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_last !== 1'b0 || out_data !== ~blk[0][127:96] ||
          aes_pt_valid !== 1'b0 || in_ready !== 1'b0) begin
        stall_ok = 1'b0;
      end
    end
    checks++;
    if (stall_ok !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall_stable: stable=%b required 1 (last out_data=%h)", stall_ok, out_data);
    end
    serve_collect(12);
    for (int i = 0; i < 12; i++) begin
      logic [127:0] e;
      logic [31:0]  ew;
      e  = ~blk[i / 4];
      ew = e[127 - 32*(i % 4) -: 32];
      checks++;
      if (got_w[i] !== ew || got_l[i] !== ((i % 4) == 3)) begin
        errors++;
        $display("FAIL bp_word%0d: data=%h last=%b required %h %b", i, got_w[i], got_l[i], ew, ((i % 4) == 3));
      end
    end
    checks++;
    if (blocks_done !== 16'd3) begin
      errors++;
      $display("FAIL bp_blocks_done: blocks_done=%0d required 3", blocks_done);
    end
  endtask

  task automatic test_key_gating();
    logic         seen;
    logic [127:0] b;
    b = 128'hcafef00d_deadbeef_00000001_80000000;
    aes_key_ready = 1'b0;
    apply_reset();
    send_block(b);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (aes_pt_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL key_gate_hold: pulse_seen=%b busy=%b required 0 1", seen, busy);
    end
    aes_key_ready = 1'b1;
    tick();
    checks++;
    if (aes_pt_valid !== 1'b0) begin
      errors++;
      $display("FAIL key_gate_k1: aes_pt_valid=%b required 0 one cycle after key rise", aes_pt_valid);
    end
    tick();
    checks++;
    if (aes_pt_valid !== 1'b1) begin
      errors++;
      $display("FAIL key_gate_k2: aes_pt_valid=%b required 1 two cycles after key rise", aes_pt_valid);
    end
    serve_collect(4);
    checks++;
    if (got_w[0] !== ~b[127:96] || got_w[3] !== ~b[31:0] || got_l[3] !== 1'b1) begin
      errors++;
      $display("FAIL key_gate_out: w0=%h w3=%h last=%b required %h %h 1", got_w[0], got_w[3], got_l[3], ~b[127:96], ~b[31:0]);
    end
  endtask

  task automatic test_timeout_error();
    logic early;
    logic any_out;
    apply_reset();
    send_block(128'h10203040_50607080_90a0b0c0_d0e0f000);
    tick();
    checks++;
    if (aes_pt_valid !== 1'b1) begin
      errors++;
      $display("FAIL to_launch: aes_pt_valid=%b required 1", aes_pt_valid);
    end
    early = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      tick();
      if (err_timeout) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL to_early: err_timeout_seen=%b busy=%b required 0 1 through LAUNCH+%0d", early, busy, TIMEOUT);
    end
    tick();
    checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL to_flag: err_timeout=%b busy=%b out_valid=%b required 1 0 0", err_timeout, busy, out_valid);
    end

    send_block(128'h0badc0de_0badc0de_0badc0de_0badc0de);
    tick();
    tick();
    aes_error = 1'b1;
    tick();
    aes_error = 1'b0;
    checks++;
    if (err_aes !== 1'b1 || err_timeout !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_flag: err_aes=%b err_timeout=%b busy=%b required 1 1 0", err_aes, err_timeout, busy);
    end
    any_out = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) any_out = 1'b1;
      tick();
    end
    checks++;
    if (any_out !== 1'b0) begin
      errors++;
      $display("FAIL err_no_output: out_valid_seen=%b required 0", any_out);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (err_aes !== 1'b0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL clr_err: err_aes=%b err_timeout=%b required 0 0", err_aes, err_timeout);
    end

    send_block(128'h77777777_66666666_55555555_44444444);
    tick();
    tick();
    aes_error = 1'b1;
    clr_err   = 1'b1;
    tick();
    aes_error = 1'b0;
    clr_err   = 1'b0;
    checks++;
    if (err_aes !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_priority: err_aes=%b busy=%b required 0 0", err_aes, busy);
    end
  endtask

  task automatic test_stale_ready();
    logic         any_out;
    logic [127:0] b;
    b = 128'h13579bdf_2468ace0_fedcba98_01234567;
    apply_reset();
    aes_ct     = 128'hdeaddeaddeaddeaddeaddeaddeaddead;
    aes_ct_rdy = 1'b1;
    send_block(b);
    tick();
    checks++;
    if (aes_pt_valid !== 1'b1) begin
      errors++;
      $display("FAIL stale_launch: aes_pt_valid=%b required 1", aes_pt_valid);
    end
    any_out = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid) any_out = 1'b1;
    end
    checks++;
    if (any_out !== 1'b0) begin
      errors++;
      $display("FAIL stale_capture: out_valid_seen=%b required 0 while ct_rdy stuck high", any_out);
    end
    aes_ct_rdy = 1'b0;
    tick();
    aes_ct     = ~b;
    aes_ct_rdy = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== ~b[127:96]) begin
      errors++;
      $display("FAIL stale_rearm: out_valid=%b out_data=%h required 1 %h", out_valid, out_data, ~b[127:96]);
    end
    serve_collect(4);
    aes_ct_rdy = 1'b0;
    checks++;
    if (got_w[2] !== ~b[63:32] || got_l[3] !== 1'b1 || blocks_done !== 16'd1) begin
      errors++;
      $display("FAIL stale_drain: w2=%h last=%b blocks_done=%0d required %h 1 1", got_w[2], got_l[3], blocks_done, ~b[63:32]);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [127:0] b;
    b = 128'h0f0f0f0f_f0f0f0f0_12345678_9abcdef0;
    send_block(128'haaaaaaaa_bbbbbbbb_cccccccc_dddddddd);
    serve_collect(2);
    checks++;
    if (out_valid !== 1'b1 || blocks_done !== 16'd1) begin
      errors++;
      $display("FAIL mid_pre: out_valid=%b blocks_done=%0d required 1 1", out_valid, blocks_done);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || blocks_done !== 16'd0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b blocks_done=%0d in_ready=%b busy=%b required 0 0 0 0",
               out_valid, blocks_done, in_ready, busy);
    end
    tick();
    tick();
    resetn     = 1'b1;
    aes_ct_rdy = 1'b0;
    tick();
    send_block(b);
    serve_collect(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_w[i] !== ~b[127 - 32*i -: 32] || got_l[i] !== (i == 3)) begin
        errors++;
        $display("FAIL mid_after_word%0d: data=%h last=%b required %h %b", i, got_w[i], got_l[i], ~b[127 - 32*i -: 32], (i == 3));
      end
    end
    checks++;
    if (blocks_done !== 16'd1) begin
      errors++;
      $display("FAIL mid_after_done: blocks_done=%0d required 1", blocks_done);
    end
  endtask

  initial begin
    test_reset();
    test_single_fips();
    test_back_to_back();
    test_key_gating();
    test_timeout_error();
    test_stale_ready();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
